// File: rtl/multi_btn_debounce.sv
// Multi-channel button debouncer: per-channel synchroniser, four-state debounce FSM, press/release pulses.
// Optional auto-repeat of btn_press while held is enabled by defining BTN_AUTOREPEAT_EN.
module multi_btn_debounce #(
  parameter int NUM_BTNS        = 5,
  parameter int SYNC_STAGES     = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] btn_in,
  output logic [NUM_BTNS-1:0] btn_state,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam bit CFG_OK = (NUM_BTNS >= 1) && (NUM_BTNS <= 32) &&
                          (SYNC_STAGES >= 2) && (SYNC_STAGES <= 4) &&
                          (DEBOUNCE_CYCLES >= 1) &&
                          (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);

  if (!CFG_OK) begin : g_bad_cfg
    $error("multi_btn_debounce: parameter out of range");
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
`endif

  typedef enum logic [1:0] {LOW, LOW_TO_HIGH, HIGH, HIGH_TO_LOW} state_t;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_q;
    state_t                 state;
    logic [CW-1:0]          cnt;
    logic                   st;
    logic                   press;
    logic                   rel;
`ifdef BTN_AUTOREPEAT_EN
    logic [RW-1:0]          rep;
    logic                   repeating;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= '0;
      else        sync <= {sync[SYNC_STAGES-2:0], btn_in[i]};
    end

    assign sync_q = sync[SYNC_STAGES-1];

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive mismatched samples.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= LOW;
        cnt   <= '0;
        st    <= 1'b0;
        press <= 1'b0;
        rel   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rep       <= '0;
        repeating <= 1'b0;
`endif
      end else begin
        press <= 1'b0;
        rel   <= 1'b0;
        case (state)
          LOW: begin
            cnt <= '0;
            if (sync_q) begin
              if (DEBOUNCE_CYCLES == 1) begin
                state <= HIGH;
                st    <= 1'b1;
                press <= 1'b1;
              end else begin
                state <= LOW_TO_HIGH;
                cnt   <= CW'(1);
              end
            end
          end
          LOW_TO_HIGH: begin
            if (!sync_q) begin
              state <= LOW;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state <= HIGH;
              cnt   <= '0;
              st    <= 1'b1;
              press <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HIGH: begin
            cnt <= '0;
            if (!sync_q) begin
              if (DEBOUNCE_CYCLES == 1) begin
                state <= LOW;
                st    <= 1'b0;
                rel   <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                rep       <= '0;
                repeating <= 1'b0;
`endif
              end else begin
                state <= HIGH_TO_LOW;
                cnt   <= CW'(1);
              end
            end
`ifdef BTN_AUTOREPEAT_EN
            // The first repeat waits REPEAT_DELAY cycles, later ones REPEAT_PERIOD.
            else if (rep == (repeating ? PERIOD_LAST : DELAY_LAST)) begin
              press     <= 1'b1;
              rep       <= '0;
              repeating <= 1'b1;
            end else begin
              rep <= rep + 1'b1;
            end
`endif
          end
          HIGH_TO_LOW: begin
            if (sync_q) begin
              state <= HIGH;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state <= LOW;
              cnt   <= '0;
              st    <= 1'b0;
              rel   <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
              rep       <= '0;
              repeating <= 1'b0;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= LOW;
            cnt   <= '0;
            st    <= 1'b0;
          end
        endcase
      end
    end

    assign btn_state[i]   = st;
    assign btn_press[i]   = press;
    assign btn_release[i] = rel;
  end

endmodule

// File: tb/tb_multi_btn_debounce.sv
// Scoreboard bench for multi_btn_debounce (2 channels, 3 sync stages, 4-cycle debounce).
// Expected outputs are derived from the edges at which each channel should rise and fall.
module tb_multi_btn_debounce;

  localparam int NB    = 2;
  localparam int NEVER = 1000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] btn_in = '0;
  logic [NB-1:0] btn_state;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;

  typedef struct {
    string      tag;
    logic [5:0] val;
  } exp_t;

  exp_t          exp_q[$];
  logic [NB-1:0] stim_q[$];
  int            vec_count = 0;
  int            err_count = 0;

  multi_btn_debounce #(
    .NUM_BTNS(NB),
    .SYNC_STAGES(3),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_in(btn_in),
    .btn_state(btn_state),
    .btn_press(btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [5:0] outputs_now();
    return {btn_state, btn_press, btn_release};
  endfunction

  // Per-channel expectation {state, press, release} at edge k, from rise/fall edges.
  function automatic logic [2:0] chan_exp(int k, logic init_b, int rise, int fall);
    logic st, pr, rl;
    st = init_b ? (k < fall) : (k >= rise && k < fall);
    pr = (k == rise);
`ifdef BTN_AUTOREPEAT_EN
    if (!init_b && k > rise && k < fall - 3 && (k - rise) >= 10 && ((k - rise - 10) % 5) == 0)
      pr = 1'b1;
`endif
    rl = (k == fall);
    return {st, pr, rl};
  endfunction

  function automatic logic [5:0] expect_at(int k, logic [1:0] init, int r0, int f0, int r1, int f1);
    logic [2:0] c0, c1;
    c0 = chan_exp(k, init[0], r0, f0);
    c1 = chan_exp(k, init[1], r1, f1);
    return {c1[2], c0[2], c1[1], c0[1], c1[0], c0[0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [5:0] observed, input logic [5:0] expected);
    vec_count++;
    if (observed !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got state/press/release=%b_%b_%b, want %b_%b_%b", tag,
               observed[5:4], observed[3:2], observed[1:0],
               expected[5:4], expected[3:2], expected[1:0]);
    end
  endtask

  task automatic applyStimulus(input string tag, input int k, input logic [NB-1:0] val,
                               input logic [5:0] expected);
    exp_t e;
    btn_in = val;
    e.tag  = $sformatf("%s@%0d", tag, k);
    e.val  = expected;
    exp_q.push_back(e);
  endtask

  task automatic push_stim(input logic [NB-1:0] val, input int n);
    for (int i = 0; i < n; i++) stim_q.push_back(val);
  endtask

  task automatic run_scenario(input string tag, input logic [1:0] init,
                              input int r0, input int f0, input int r1, input int f1);
    int   n;
    exp_t e;
    n = stim_q.size();
    for (int k = 1; k <= n; k++) begin
      applyStimulus(tag, k, stim_q.pop_front(), expect_at(k, init, r0, f0, r1, f1));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checkOutput(e.tag, outputs_now(), e.val);
    end
  endtask

  initial begin
    btn_in = 2'b11;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_hold", outputs_now(), 6'b0);
    rst_n = 1'b1;

    push_stim(2'b11, 10);
    run_scenario("reset_release", 2'b00, 7, NEVER, 7, NEVER);

    push_stim(2'b00, 10);
    run_scenario("release_both", 2'b11, NEVER, 7, NEVER, 7);

    push_stim(2'b01, 20);
    push_stim(2'b00, 10);
    run_scenario("clean_ch0", 2'b00, 7, 27, NEVER, NEVER);

    stim_q = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    push_stim(2'b00, 10);
    run_scenario("bounce", 2'b00, NEVER, NEVER, NEVER, NEVER);

    push_stim(2'b10, 10);
    run_scenario("ch1_setup", 2'b00, NEVER, NEVER, 7, NEVER);
    push_stim(2'b01, 10);
    run_scenario("simultaneous", 2'b10, 7, NEVER, NEVER, 7);
    push_stim(2'b00, 10);
    run_scenario("ch0_release", 2'b01, NEVER, 7, NEVER, NEVER);

    push_stim(2'b01, 5);
    run_scenario("mid_debounce", 2'b00, NEVER, NEVER, NEVER, NEVER);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_debounce", outputs_now(), 6'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_stim(2'b01, 10);
    run_scenario("press_after_rst", 2'b00, 7, NEVER, NEVER, NEVER);

    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_high", outputs_now(), 6'b0);
    btn_in = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_stim(2'b00, 8);
    run_scenario("quiet_after_rst", 2'b00, NEVER, NEVER, NEVER, NEVER);

    push_stim(2'b01, 40);
    push_stim(2'b00, 10);
    run_scenario("long_hold", 2'b00, 7, 47, NEVER, NEVER);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
